// File: rtl/acc_display_scanner.sv
// Scans NODES signed accumulators onto six 7-segment digits: node index, sign, decimal magnitude.
// Optional macro ACCDISP_AUTOSCROLL_EN adds the auto_scroll input and a scroll counter of refresh ticks.
module acc_display_scanner #(
    parameter int NODES          = 12,
    parameter int WIDTH          = 11,
    parameter int REFRESH_CYCLES = 50000,
    parameter int SCROLL_TICKS   = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NODES*WIDTH-1:0]   acc_flat,
    input  logic                     next_btn,
    input  logic                     prev_btn,
`ifdef ACCDISP_AUTOSCROLL_EN
    input  logic                     auto_scroll,
`endif
    output logic [$clog2(NODES)-1:0] sel,
    output logic                     busy,
    output logic [6:0]               hex5,
    output logic [6:0]               hex4,
    output logic [6:0]               hex3,
    output logic [6:0]               hex2,
    output logic [6:0]               hex1,
    output logic [6:0]               hex0
);
    localparam int SEL_W = $clog2(NODES);
    localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    if (NODES < 2 || NODES > 99 || WIDTH < 4 || WIDTH > 16 ||
        REFRESH_CYCLES < 2 || SCROLL_TICKS < 1) begin : g_param_check
        $error("acc_display_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    logic [2:0]       next_sr, prev_sr;
    logic             next_pulse, prev_pulse, btn_any;
    logic             step_up, step_dn, sel_chg;
    logic             scroll_step;
    logic [REF_W-1:0] ref_cnt;
    logic             ref_tick;

    state_t           state, state_nx;
    logic [BIT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] mag_sr;
    logic [11:0]      bcd;
    logic [6:0]       idx_q;
    logic             neg_q, ovf_q;

    logic signed [WIDTH-1:0] val;
    logic [WIDTH-1:0]        mag;

    // Sync stages [1:0] plus edge register [2]; pulse on the synchronised rising edge.
    assign next_pulse = next_sr[1] & ~next_sr[2];
    assign prev_pulse = prev_sr[1] & ~prev_sr[2];
    assign btn_any    = next_pulse | prev_pulse;
    assign ref_tick   = (ref_cnt == REF_W'(REFRESH_CYCLES - 1));

`ifdef ACCDISP_AUTOSCROLL_EN
    localparam int SCR_W = $clog2(SCROLL_TICKS + 1);
    logic [SCR_W-1:0] scroll_cnt;

    assign scroll_step = auto_scroll & ref_tick & ~btn_any &
                         (scroll_cnt == SCR_W'(SCROLL_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_cnt <= '0;
        end else if (!auto_scroll || btn_any || scroll_step) begin
            scroll_cnt <= '0;
        end else if (ref_tick) begin
            scroll_cnt <= scroll_cnt + SCR_W'(1);
        end
    end
`else
    assign scroll_step = 1'b0;
`endif

    // Opposing requests in one cycle cancel; a scroll step never coincides with a button pulse.
    assign step_up = (next_pulse | scroll_step) & ~prev_pulse;
    assign step_dn = prev_pulse & ~next_pulse;
    assign sel_chg = step_up | step_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_sr <= '0;
            prev_sr <= '0;
            ref_cnt <= '0;
            sel     <= '0;
        end else begin
            next_sr <= {next_sr[1:0], next_btn};
            prev_sr <= {prev_sr[1:0], prev_btn};
            ref_cnt <= ref_tick ? '0 : ref_cnt + REF_W'(1);
            if (step_up) begin
                sel <= (sel == SEL_W'(NODES - 1)) ? '0 : sel + SEL_W'(1);
            end else if (step_dn) begin
                sel <= (sel == '0) ? SEL_W'(NODES - 1) : sel - SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        case (state)
            IDLE:    if (sel_chg || ref_tick) state_nx = LOAD;
            LOAD:    state_nx = sel_chg ? LOAD : SHIFT;
            SHIFT: begin
                if (sel_chg)                             state_nx = LOAD;
                else if (bit_cnt == BIT_W'(WIDTH - 1))   state_nx = DONE;
            end
            DONE:    state_nx = sel_chg ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Magnitude kept WIDTH bits unsigned so the most negative value converts exactly.
    assign val = acc_flat[int'(sel)*WIDTH +: WIDTH];
    assign mag = val[WIDTH-1] ? $unsigned(-val) : $unsigned(val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            mag_sr  <= '0;
            bcd     <= '0;
            idx_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            hex5    <= SEG_BLANK;
            hex4    <= SEG_BLANK;
            hex3    <= SEG_BLANK;
            hex2    <= SEG_BLANK;
            hex1    <= SEG_BLANK;
            hex0    <= SEG_BLANK;
        end else begin
            case (state)
                LOAD: begin
                    idx_q   <= 7'(sel);
                    neg_q   <= val[WIDTH-1];
                    ovf_q   <= (32'(mag) > 32'd999);
                    mag_sr  <= mag;
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    bcd     <= {dd_adjust(bcd), mag_sr[WIDTH-1]} >> 0;
                    mag_sr  <= mag_sr << 1;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
                DONE: begin
                    hex5 <= (idx_q < 7'd10) ? SEG_BLANK : seg7(4'(idx_q / 7'd10));
                    hex4 <= seg7(4'(idx_q % 7'd10));
                    hex3 <= neg_q ? SEG_MINUS : SEG_BLANK;
                    if (ovf_q) begin
                        hex2 <= SEG_MINUS;
                        hex1 <= SEG_MINUS;
                        hex0 <= SEG_MINUS;
                    end else begin
                        hex2 <= (bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
                        hex1 <= (bcd[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd[7:4]);
                        hex0 <= seg7(bcd[3:0]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_display_scanner.sv
// Directed bench for acc_display_scanner (NODES=12, WIDTH=11, REFRESH_CYCLES=16, SCROLL_TICKS=2).
`timescale 1ns/1ps
module tb_acc_display_scanner;
    localparam int NODES          = 12;
    localparam int WIDTH          = 11;
    localparam int REFRESH_CYCLES = 16;
    localparam int SCROLL_TICKS   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NODES*WIDTH-1:0]   acc_flat;
    logic                     next_btn, prev_btn;
`ifdef ACCDISP_AUTOSCROLL_EN
    logic                     auto_scroll;
`endif
    logic [3:0]               sel;
    logic                     busy;
    logic [6:0]               hex5, hex4, hex3, hex2, hex1, hex0;
    logic [41:0]              disp;
    logic [41:0]              exp_disp;
    int                       n_checks = 0;
    int                       n_fail = 0;
    int                       cyc;

    acc_display_scanner #(
        .NODES(NODES), .WIDTH(WIDTH),
        .REFRESH_CYCLES(REFRESH_CYCLES), .SCROLL_TICKS(SCROLL_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .acc_flat(acc_flat),
        .next_btn(next_btn), .prev_btn(prev_btn),
`ifdef ACCDISP_AUTOSCROLL_EN
        .auto_scroll(auto_scroll),
`endif
        .sel(sel), .busy(busy),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
    );

    always #5 clk = ~clk;
    assign disp = {hex5, hex4, hex3, hex2, hex1, hex0};

    // Cycle number since reset release; equals the refresh counter phase modulo 16.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_mod(input int m);
        do step(1); while ((cyc % REFRESH_CYCLES) != m);
    endtask

    task automatic set_acc(input int k, input logic signed [WIDTH-1:0] v);
        acc_flat[k*WIDTH +: WIDTH] = v;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(3);
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        exp_disp = {6{7'h7F}};
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL reset_disp: got %h want %h", disp, exp_disp); end
    endtask

    task automatic test_first_conversion;
        @(posedge clk); #1 rst_n = 1'b1;
        step(14);
        exp_disp = {6{7'h7F}};
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL pre_tick_disp: got %h want %h", disp, exp_disp); end
        step(1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tick_cycle_busy: got %b want 0", busy); end
        step(1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b want 1", busy); end
        step(12);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL done_busy: got %b want 1", busy); end
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL cycle28_disp: got %h want %h", disp, exp_disp); end
        step(1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cycle29_busy: got %b want 0", busy); end
        exp_disp = {7'h7F, 7'h40, 7'h3F, 7'h7F, 7'h19, 7'h24};
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL minus42_disp: got %h want %h", disp, exp_disp); end
    endtask

    task automatic test_ovf_zero;
        set_acc(0, -11'sd1024);
        step(40);
        exp_disp = {7'h7F, 7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL ovf_disp: got %h want %h", disp, exp_disp); end
        set_acc(0, 11'sd0);
        step(40);
        exp_disp = {7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL zero_disp: got %h want %h", disp, exp_disp); end
    endtask

    task automatic test_prev_wrap;
        prev_btn = 1'b1;
        step(2);
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL prev_early_sel: got %0d want 0", sel); end
        step(1);
        n_checks++; if (sel !== 4'd11) begin n_fail++; $display("FAIL prev_wrap_sel: got %0d want 11", sel); end
        step(12);
        exp_disp = {7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL prev_old_disp: got %h want %h", disp, exp_disp); end
        step(1);
        exp_disp = {7'h79, 7'h79, 7'h7F, 7'h30, 7'h40, 7'h12};
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL node11_disp: got %h want %h", disp, exp_disp); end
        prev_btn = 1'b0;
        step(4);
    endtask

    task automatic test_next_wrap;
        next_btn = 1'b1;
        step(3);
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL next_wrap_sel: got %0d want 0", sel); end
        next_btn = 1'b0;
        step(20);
        exp_disp = {7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL node0_disp: got %h want %h", disp, exp_disp); end
    endtask

    task automatic test_both_buttons;
        wait_mod(11);
        next_btn = 1'b1;
        prev_btn = 1'b1;
        step(3);
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL both_sel: got %0d want 0", sel); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_busy: got %b want 0", busy); end
        step(4);
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL both_sel_late: got %0d want 0", sel); end
        next_btn = 1'b0;
        prev_btn = 1'b0;
        step(4);
    endtask

    task automatic test_abort;
        wait_mod(3);
        next_btn = 1'b1;
        step(3);
        n_checks++; if (sel !== 4'd1) begin n_fail++; $display("FAIL abort_sel: got %0d want 1", sel); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_load_busy: got %b want 1", busy); end
        step(12);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_done_busy: got %b want 1", busy); end
        exp_disp = {7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL abort_old_disp: got %h want %h", disp, exp_disp); end
        step(1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_busy: got %b want 0", busy); end
        exp_disp = {7'h7F, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h78};
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL node1_disp: got %h want %h", disp, exp_disp); end
        next_btn = 1'b0;
        step(4);
    endtask

`ifdef ACCDISP_AUTOSCROLL_EN
    task automatic test_autoscroll;
        logic [3:0] s0;
        int         k;
        auto_scroll = 1'b1;
        s0 = sel;
        k = 0;
        while (sel == s0 && k < 40) begin step(1); k++; end
        n_checks++; if (sel !== s0 + 4'd1) begin n_fail++; $display("FAIL scroll_first: got %0d want %0d", sel, s0 + 4'd1); end
        step(31);
        n_checks++; if (sel !== s0 + 4'd1) begin n_fail++; $display("FAIL scroll_hold: got %0d want %0d", sel, s0 + 4'd1); end
        step(1);
        n_checks++; if (sel !== s0 + 4'd2) begin n_fail++; $display("FAIL scroll_period: got %0d want %0d", sel, s0 + 4'd2); end
        k = 0;
        while (sel != 4'd11 && k < 500) begin step(1); k++; end
        n_checks++; if (sel !== 4'd11) begin n_fail++; $display("FAIL scroll_reach11: got %0d want 11", sel); end
        k = 0;
        while (sel == 4'd11 && k < 40) begin step(1); k++; end
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL scroll_wrap: got %0d want 0", sel); end
        auto_scroll = 1'b0;
        step(40);
    endtask
`endif

    task automatic test_async_reset;
        wait_mod(5);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL shift_busy: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL areset_sel: got %0d want 0", sel); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy); end
        exp_disp = {6{7'h7F}};
        n_checks++; if (disp !== exp_disp) begin n_fail++; $display("FAIL areset_disp: got %h want %h", disp, exp_disp); end
        step(2);
    endtask

    initial begin
        acc_flat = '0;
        next_btn = 1'b0;
        prev_btn = 1'b0;
`ifdef ACCDISP_AUTOSCROLL_EN
        auto_scroll = 1'b0;
`endif
        set_acc(0, -11'sd42);
        set_acc(1, 11'sd7);
        set_acc(11, 11'sd305);
        test_reset();
        test_first_conversion();
        test_ovf_zero();
        test_prev_wrap();
        test_next_wrap();
        test_both_buttons();
        test_abort();
`ifdef ACCDISP_AUTOSCROLL_EN
        test_autoscroll();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
